bus_arbiter: RTL and testbench



---
 rtl/bus_arbiter_if.sv | 30 +++
 rtl/bus_arbiter.sv | 92 +++++++++
 tb/tb_bus_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Shared split-transaction bus bundle: per-agent request/command lanes in, grant and broadcast bus out.
// master = arbiter side, slave = agent side.
interface bus_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    agt_req;
  logic [3*NREQ-1:0]  agt_cmd;
  logic [5*NREQ-1:0]  agt_tag;
  logic [30*NREQ-1:0] agt_addr;
  logic [64*NREQ-1:0] agt_data;
  logic [NREQ-1:0]    agt_nack;
  logic [NREQ-1:0]    agt_grant;
  logic [2:0]         bus_cycle;
  logic               bus_valid;
  logic [2:0]         bus_cmd;
  logic [4:0]         bus_tag;
  logic [29:0]        bus_addr;
  logic [63:0]        bus_data;
  logic               bus_nack;

  modport master (
    input  agt_req, agt_cmd, agt_tag, agt_addr, agt_data, agt_nack,
    output agt_grant, bus_cycle, bus_valid, bus_cmd, bus_tag, bus_addr, bus_data, bus_nack
  );

  modport slave (
    output agt_req, agt_cmd, agt_tag, agt_addr, agt_data, agt_nack,
    input  agt_grant, bus_cycle, bus_valid, bus_cmd, bus_tag, bus_addr, bus_data, bus_nack
  );
endinterface

// File: rtl/bus_arbiter.sv
// 8-beat slot arbiter/mux: beat counter, round-robin grant in beat 7, owner mux for the next slot.
// Define BUSARB_FIXED_PRIO_EN for lowest-index-wins fixed priority instead of round-robin.
module bus_arbiter #(
  parameter int NREQ = 4
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.master bus
);
  logic [2:0]      cycle_q, cycle_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] owner_q, owner_d;
  logic [NREQ-1:0] pick;
  logic            found;

`ifdef BUSARB_FIXED_PRIO_EN
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && bus.agt_req[i]) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end
`else
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [PW-1:0] ptr_q, ptr_d, pick_idx;

  // Search starts one past the last winner; k walks distance, i stays constant so no dynamic index.
  always_comb begin
    pick     = '0;
    pick_idx = ptr_q;
    found    = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && bus.agt_req[i] && (((int'(ptr_q) + k) % NREQ) == i)) begin
          pick[i]  = 1'b1;
          pick_idx = PW'(i);
          found    = 1'b1;
        end
      end
    end
    ptr_d = ptr_q;
    if (cycle_q == 3'd6 && found) ptr_d = pick_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= PW'(NREQ - 1);
    else     ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    cycle_d = cycle_q + 3'd1;
    grant_d = (cycle_q == 3'd6) ? pick : '0;
    owner_d = (cycle_q == 3'd7) ? grant_q : owner_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q <= '0;
      grant_q <= '0;
      owner_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
    end
  end

  assign bus.agt_grant = grant_q;
  assign bus.bus_cycle = cycle_q;

  always_comb begin
    bus.bus_cmd  = '0;
    bus.bus_tag  = '0;
    bus.bus_addr = '0;
    bus.bus_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q[i]) begin
        bus.bus_cmd  = bus.agt_cmd[3*i +: 3];
        bus.bus_tag  = bus.agt_tag[5*i +: 5];
        bus.bus_addr = bus.agt_addr[30*i +: 30];
        bus.bus_data = bus.agt_data[64*i +: 64];
      end
    end
    bus.bus_valid = (|owner_q) && (cycle_q == 3'd0);
    bus.bus_nack  = bus.bus_valid & (|bus.agt_nack);
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// Slot-level scoreboard bench for bus_arbiter: expected winners queued per slot, bus outputs checked every beat.
module tb_bus_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_arbiter_if #(.NREQ(N)) bif();
  bus_arbiter #(.NREQ(N)) dut (.clk(clk), .rst(rst), .bus(bif));

  int n_cmp = 0;
  int n_err = 0;
  int win_q[$];
  int exp_owner  = -1;
  int next_owner = -1;
  int tb_cyc     = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0]  a_cmd(input int i);  return 3'(i + 1); endfunction
  function automatic logic [4:0]  a_tag(input int i);  return 5'(5 * i + 3); endfunction
  function automatic logic [29:0] a_addr(input int i); return 30'(32'h1000 * (i + 1) + i); endfunction
  function automatic logic [63:0] a_data(input int i, input int b);
    return {8'(i + 1), 48'h0000_CAFE_0000, 8'(b)};
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bif.agt_cmd[3*i +: 3]   = a_cmd(i);
      bif.agt_tag[5*i +: 5]   = a_tag(i);
      bif.agt_addr[30*i +: 30] = a_addr(i);
      bif.agt_data[64*i +: 64] = a_data(i, tb_cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cycle"}, 64'(bif.bus_cycle), 64'd0);
    chk({tag, "_grant"}, 64'(bif.agt_grant), 64'd0);
    chk({tag, "_valid"}, 64'(bif.bus_valid), 64'd0);
    chk({tag, "_cmd"},   64'(bif.bus_cmd),   64'd0);
    chk({tag, "_tag"},   64'(bif.bus_tag),   64'd0);
    chk({tag, "_addr"},  64'(bif.bus_addr),  64'd0);
    chk({tag, "_data"},  bif.bus_data,       64'd0);
    chk({tag, "_nack"},  64'(bif.bus_nack),  64'd0);
  endtask

  task automatic check_beat();
    logic [N-1:0] eg;
    logic         vld;
    int           w;
    eg = '0;
    chk("cycle", 64'(bif.bus_cycle), 64'(tb_cyc));
    if (tb_cyc == 7) begin
      w = (win_q.size() > 0) ? win_q.pop_front() : -1;
      if (w >= 0) eg = N'(1 << w);
      next_owner = w;
    end
    chk("grant", 64'(bif.agt_grant), 64'(eg));
    vld = (exp_owner >= 0) && (tb_cyc == 0);
    chk("valid", 64'(bif.bus_valid), 64'(vld));
    chk("cmd",  64'(bif.bus_cmd),  (exp_owner >= 0) ? 64'(a_cmd(exp_owner))  : 64'd0);
    chk("tag",  64'(bif.bus_tag),  (exp_owner >= 0) ? 64'(a_tag(exp_owner))  : 64'd0);
    chk("addr", 64'(bif.bus_addr), (exp_owner >= 0) ? 64'(a_addr(exp_owner)) : 64'd0);
    chk("data", bif.bus_data,      (exp_owner >= 0) ? a_data(exp_owner, tb_cyc) : 64'd0);
    chk("nack", 64'(bif.bus_nack), 64'(vld && (|bif.agt_nack)));
  endtask

  // One beat: drive at negedge, check 1ns later, advance across the posedge.
  task automatic beat();
    drive();
    #1;
    check_beat();
    @(posedge clk);
    if (tb_cyc == 7) exp_owner = next_owner;
    tb_cyc = (tb_cyc + 1) % 8;
    @(negedge clk);
  endtask

  task automatic run_slot(input logic [N-1:0] req, input int win, input int set_b, input bit drop7);
    win_q.push_back(win);
    for (int b = 0; b < 8; b++) begin
      if (b == set_b) bif.agt_req = req;
      if (drop7 && b == 7) bif.agt_req = '0;
      beat();
    end
  endtask

  initial begin
    bif.agt_req  = '0;
    bif.agt_nack = '0;
    drive();
    @(negedge clk);
    #1;
    chk_zero("rst");
    @(negedge clk);
    rst = 1'b0;

    // single requester, then its owned slot
    run_slot(4'b0100, 2, 1, 1'b0);
    run_slot(4'b0000, -1, 1, 1'b0);
    // idle slots
    run_slot(4'b0000, -1, 1, 1'b0);
    run_slot(4'b0000, -1, 1, 1'b0);
`ifdef BUSARB_FIXED_PRIO_EN
    for (int s = 0; s < 4; s++) run_slot(4'b0011, 0, 1, 1'b0);
    for (int s = 0; s < 3; s++) run_slot(4'b1111, 0, 1, 1'b0);
    for (int s = 0; s < 3; s++) run_slot(4'b1010, 1, 1, 1'b0);
`else
    run_slot(4'b0011, 0, 1, 1'b0);
    run_slot(4'b0011, 1, 1, 1'b0);
    run_slot(4'b0011, 0, 1, 1'b0);
    run_slot(4'b0011, 1, 1, 1'b0);
    run_slot(4'b1111, 2, 1, 1'b0);
    run_slot(4'b1111, 3, 1, 1'b0);
    run_slot(4'b1111, 0, 1, 1'b0);
`endif
    run_slot(4'b0000, -1, 1, 1'b0);
    // late request in beat 7 waits a slot; then req dropped right after its grant
    run_slot(4'b1000, -1, 7, 1'b0);
    run_slot(4'b1000, 3, 1, 1'b1);
    // owner 3 slot with nack held: bus_nack only in beat 0
    bif.agt_nack = 4'b1000;
    run_slot(4'b0000, -1, 1, 1'b0);
    bif.agt_nack = '0;
    // lone requester wins back-to-back
    run_slot(4'b0010, 1, 1, 1'b0);
    run_slot(4'b0010, 1, 1, 1'b0);
    run_slot(4'b0001, 0, 1, 1'b0);
    // reset asserted in beat 4 of agent 0's slot
    bif.agt_req = '0;
    for (int b = 0; b < 4; b++) beat();
    drive();
    #1;
    chk("pre_rst_owner_cmd", 64'(bif.bus_cmd), 64'(a_cmd(0)));
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    tb_cyc = 0;
    exp_owner = -1;
    win_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk_zero("rsthold");
    rst = 1'b0;
    run_slot(4'b1001, 0, 1, 1'b0);
    run_slot(4'b0000, -1, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
